// File: rtl/reg_out_fifo.sv
// Capture FIFO behind the enabled 8-bit register: buffers every enabled word and
// drains it over valid/ready; words arriving while full are dropped and flagged.
module reg_out_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [LW-1:0]    level,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    input  logic             clr_ovf
);
    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [LW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [LW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic             overflow_reg, overflow_next;
    logic [WIDTH-1:0] mem_reg [DEPTH];

    logic pop;
    logic push;
    logic drop;

    assign level     = wr_ptr_reg - rd_ptr_reg;
    assign empty     = (wr_ptr_reg == rd_ptr_reg);
    assign full      = (level == LW'(DEPTH));
    assign out_valid = !empty;
    assign overflow  = overflow_reg;
    assign out_data  = out_valid ? mem_reg[rd_ptr_reg[AW-1:0]] : '0;

    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign pop  = out_valid && out_ready;
    assign push = in_valid && (!full || pop);
    assign drop = in_valid && full && !pop;

    always_comb begin
        wr_ptr_next   = push ? wr_ptr_reg + LW'(1) : wr_ptr_reg;
        rd_ptr_next   = pop  ? rd_ptr_reg + LW'(1) : rd_ptr_reg;
        overflow_next = overflow_reg;
        if (drop) begin
            overflow_next = 1'b1;
        end else if (clr_ovf) begin
            overflow_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            overflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            overflow_reg <= overflow_next;
        end
    end

    // Storage holds no reset; validity is tracked entirely by the pointers.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_reg[AW-1:0] == AW'(gi))) begin
                    mem_reg[gi] <= in_data;
                end
            end
        end
    endgenerate

endmodule
